// File: rtl/uart_baud_gen.sv
// uart_baud_gen: UART baud tick generator with a runtime-programmable integer
// divisor, built-in oversampling and an optional fractional divisor.
// Optional feature macro: UART_BAUD_FRAC_EN (fractional divisor accumulator).
// Produces rx_tick (OVERSAMPLE per bit), rx_mid (bit centre) and tx_tick
// (one per bit) as registered single-cycle strobes.
module uart_baud_gen #(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_RST    = 27
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic             bps_en,
    input  logic [DIV_W-1:0] div_int,
    input  logic [3:0]       div_frac,
    input  logic             div_load,
    input  logic             rx_resync,
    output logic             rx_tick,
    output logic             rx_mid,
    output logic             tx_tick,
    output logic             cfg_pending
);

    localparam int SUB_W = $clog2(OVERSAMPLE);
    // One extra bit so a full-scale divisor plus the fractional stretch fits.
    localparam int CNT_W = DIV_W + 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);

    logic [CNT_W-1:0] base_cnt_reg;
    logic [SUB_W-1:0] sub_cnt_reg;
    logic [DIV_W-1:0] active_int_reg;
    logic [DIV_W-1:0] shadow_int_reg;
    logic             cfg_pending_reg;
    logic             rx_tick_reg;
    logic             rx_mid_reg;
    logic             tx_tick_reg;

    logic [CNT_W-1:0] period_base;
    logic [CNT_W-1:0] period;
    logic             period_stretch;
    logic             terminal;
    logic             tick_event;
    logic             wrap_event;
    logic             apply_cfg;

`ifdef UART_BAUD_FRAC_EN
    logic [3:0] active_frac_reg;
    logic [3:0] shadow_frac_reg;
    logic [3:0] frac_acc_reg;
    logic       frac_carry_reg;

    assign period_stretch = frac_carry_reg;
`else
    // Fractional input kept on the interface but intentionally unused here.
    logic unused_frac;
    assign unused_frac    = ^div_frac;
    assign period_stretch = 1'b0;
`endif

    // Effective period, terminal count and the events derived from it.
    always_comb begin
        period_base = (active_int_reg < DIV_W'(2)) ? CNT_W'(2) : {1'b0, active_int_reg};
        period      = period_base + {{(CNT_W-1){1'b0}}, period_stretch};
        terminal    = (base_cnt_reg == period - 1'b1);
        // A resync or disable suppresses any strobe due on this edge.
        tick_event  = bps_en && !rx_resync && terminal;
        wrap_event  = tick_event && (sub_cnt_reg == SUB_LAST);
        apply_cfg   = cfg_pending_reg && (wrap_event || !bps_en || rx_resync);
    end

    // Base and sub counters: cleared when disabled or resynchronised.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            base_cnt_reg <= '0;
            sub_cnt_reg  <= '0;
        end else if (!bps_en || rx_resync) begin
            base_cnt_reg <= '0;
            sub_cnt_reg  <= '0;
        end else if (terminal) begin
            base_cnt_reg <= '0;
            sub_cnt_reg  <= sub_cnt_reg + 1'b1;
        end else begin
            base_cnt_reg <= base_cnt_reg + 1'b1;
        end
    end

    // Registered strobes; rx_mid and tx_tick only ever ride on an rx_tick.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            rx_tick_reg <= 1'b0;
            rx_mid_reg  <= 1'b0;
            tx_tick_reg <= 1'b0;
        end else begin
            rx_tick_reg <= tick_event;
            rx_mid_reg  <= tick_event && (sub_cnt_reg == SUB_MID);
            tx_tick_reg <= wrap_event;
        end
    end

    // Shadow capture and deferred apply at a bit boundary; a load that lands
    // on the apply edge stays pending for the next boundary.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            active_int_reg  <= DIV_W'(DIV_RST);
            shadow_int_reg  <= DIV_W'(DIV_RST);
            cfg_pending_reg <= 1'b0;
        end else begin
            if (div_load) begin
                shadow_int_reg <= div_int;
            end
            if (apply_cfg) begin
                active_int_reg <= shadow_int_reg;
            end
            if (div_load) begin
                cfg_pending_reg <= 1'b1;
            end else if (apply_cfg) begin
                cfg_pending_reg <= 1'b0;
            end
        end
    end

`ifdef UART_BAUD_FRAC_EN
    // Fractional divisor shadow/active pair, applied alongside the integer part.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            active_frac_reg <= '0;
            shadow_frac_reg <= '0;
        end else begin
            if (div_load) begin
                shadow_frac_reg <= div_frac;
            end
            if (apply_cfg) begin
                active_frac_reg <= shadow_frac_reg;
            end
        end
    end

    // Sixteenths accumulator; its carry stretches the following period by one.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            frac_acc_reg   <= '0;
            frac_carry_reg <= 1'b0;
        end else if (!bps_en || rx_resync) begin
            frac_acc_reg   <= '0;
            frac_carry_reg <= 1'b0;
        end else if (tick_event) begin
            {frac_carry_reg, frac_acc_reg} <= {1'b0, frac_acc_reg} + {1'b0, active_frac_reg};
        end
    end
`endif

    assign rx_tick     = rx_tick_reg;
    assign rx_mid      = rx_mid_reg;
    assign tx_tick     = tx_tick_reg;
    assign cfg_pending = cfg_pending_reg;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed self-checking bench for uart_baud_gen
// (DIV_W=16, OVERSAMPLE=16, DIV_RST=27). Expected cycle positions are
// hand-computed; a free-running cycle counter timestamps observed strobes.
module tb_uart_baud_gen;

    logic        clk = 1'b0;
    logic        RSTn;
    logic        bps_en;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        rx_resync;
    logic        rx_tick;
    logic        rx_mid;
    logic        tx_tick;
    logic        cfg_pending;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

`ifdef UART_BAUD_FRAC_EN
    localparam int FRAC_FIRST = 71;
    localparam int FRAC_SPAN  = 72;
`else
    localparam int FRAC_FIRST = 64;
    localparam int FRAC_SPAN  = 64;
`endif

    uart_baud_gen #(.DIV_W(16), .OVERSAMPLE(16), .DIV_RST(27)) dut (
        .clk         (clk),
        .RSTn        (RSTn),
        .bps_en      (bps_en),
        .div_int     (div_int),
        .div_frac    (div_frac),
        .div_load    (div_load),
        .rx_resync   (rx_resync),
        .rx_tick     (rx_tick),
        .rx_mid      (rx_mid),
        .tx_tick     (tx_tick),
        .cfg_pending (cfg_pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
        $display("[TB] %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Wait (bounded) for a strobe: 0=rx_tick 1=rx_mid 2=tx_tick; at=-1 on timeout.
    task automatic wait_sig(input int which, input int max_cyc, output int at);
        int n;
        bit seen;
        at = -1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < max_cyc) begin
            @(negedge clk);
            n++;
            if ((which == 0 && rx_tick) || (which == 1 && rx_mid) || (which == 2 && tx_tick)) begin
                seen = 1'b1;
                at = cyc;
            end
        end
    endtask

    // Load a divisor with the generator disabled so it applies on the next clock.
    task automatic load_idle(input logic [15:0] d_int, input logic [3:0] d_frac);
        bps_en   = 1'b0;
        div_int  = d_int;
        div_frac = d_frac;
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c0, c1, r, e, f, g, h, t, t2, t3, cnt;
        RSTn = 1'b0; bps_en = 1'b0; div_int = '0; div_frac = '0;
        div_load = 1'b0; rx_resync = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({rx_tick, rx_mid, tx_tick, cfg_pending}), 0);
        RSTn = 1'b1;
        @(negedge clk);

        // Basic operation with div_int=4.
        div_int = 16'd4; div_frac = 4'd0; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        check("pending_after_load", int'(cfg_pending), 1);
        @(negedge clk);
        check("pending_idle_apply", int'(cfg_pending), 0);
        bps_en = 1'b1; c0 = cyc;
        wait_sig(0, 100, t);  check("first_rx_tick", t - c0, 4);
        wait_sig(0, 100, t);  check("second_rx_tick", t - c0, 8);
        wait_sig(1, 100, t);  check("first_rx_mid", t - c0, 32);
        check("rx_mid_with_tick", int'(rx_tick), 1);
        wait_sig(2, 100, t);  check("first_tx_tick", t - c0, 64);
        wait_sig(2, 200, t);  check("second_tx_tick", t - c0, 128);

        // Fractional divisor 4 + 8/16, applied at the next tx_tick.
        div_int = 16'd4; div_frac = 4'd8; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        wait_sig(2, 200, t);  check("frac_apply_tx", t - c0, 192);
        wait_sig(2, 200, t2); check("frac_first_bit", t2 - t, FRAC_FIRST);
        wait_sig(2, 200, t3); check("frac_steady_bit", t3 - t2, FRAC_SPAN);

        // Mid-bit reload to 8 waits for the bit boundary.
        load_idle(16'd4, 4'd0);
        bps_en = 1'b1; c1 = cyc;
        repeat (3) wait_sig(0, 100, t);
        check("reload_prior_tick", t - c1, 12);
        div_int = 16'd8; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        check("reload_pending", int'(cfg_pending), 1);
        wait_sig(0, 100, t);  check("old_spacing_kept", t - c1, 16);
        wait_sig(2, 200, t);  check("reload_tx_tick", t - c1, 64);
        check("reload_pending_clear", int'(cfg_pending), 0);
        wait_sig(0, 100, t);  check("new_spacing_8", t - c1, 72);

        // Resync on the edge where a terminal count is due; pending 4 applies now.
        div_int = 16'd4; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        repeat (6) @(negedge clk);
        rx_resync = 1'b1; r = cyc;
        @(negedge clk);
        rx_resync = 1'b0;
        check("resync_no_strobe", int'(rx_tick), 0);
        check("resync_pending_clear", int'(cfg_pending), 0);
        wait_sig(1, 200, t);  check("resync_rx_mid", t - r, 33);
        wait_sig(2, 200, t);  check("resync_tx_tick", t - r, 65);

        // Divisor clamp: 0 and 1 both behave as 2.
        load_idle(16'd0, 4'd0);
        bps_en = 1'b1; e = cyc;
        wait_sig(0, 50, t);   check("div0_first", t - e, 2);
        wait_sig(0, 50, t);   check("div0_second", t - e, 4);
        load_idle(16'd1, 4'd0);
        bps_en = 1'b1; e = cyc;
        wait_sig(0, 50, t);   check("div1_first", t - e, 2);
        wait_sig(0, 50, t);   check("div1_second", t - e, 4);

        // Disable mid-period, then re-enable.
        load_idle(16'd4, 4'd0);
        bps_en = 1'b1; f = cyc;
        wait_sig(0, 50, t);   check("en_first_tick", t - f, 4);
        repeat (2) @(negedge clk);
        bps_en = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (rx_tick || rx_mid || tx_tick) cnt++;
        end
        check("disabled_no_strobes", cnt, 0);
        bps_en = 1'b1; g = cyc;
        wait_sig(0, 50, t);   check("reenable_first_tick", t - g, 4);

        // Asynchronous reset while a strobe and a pending config are live.
        div_int = 16'd9; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        check("pre_reset_pending", int'(cfg_pending), 1);
        wait_sig(0, 50, t);   check("pre_reset_tick", int'(rx_tick), 1);
        #2 RSTn = 1'b0;
        #1 check("async_reset_outputs", int'({rx_tick, rx_mid, tx_tick, cfg_pending}), 0);
        @(negedge clk);
        RSTn = 1'b1; h = cyc;
        wait_sig(0, 100, t);  check("post_reset_first", t - h, 27);
        wait_sig(0, 100, t);  check("post_reset_second", t - h, 54);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
